// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wb_stage_if : data-memory request/acknowledge bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface mem_wb_stage_if #(
  parameter int DPW = 32
);
  logic             dmem_req;
  logic             dmem_we;
  logic [DPW-1:0]   dmem_addr;
  logic [DPW/8-1:0] dmem_be;
  logic [DPW-1:0]   dmem_wdata;
  logic             dmem_ack;
  logic [DPW-1:0]   dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wb_stage : rv32i memory/writeback stage with variable-latency dmem bus
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int DPW           = 32,
  parameter int ADW           = 5,
  parameter int TimeoutCycles = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             validM,
  input  logic             regwriteM,
  input  logic             resultsrcM,
  input  logic             memwriteM,
  input  logic [2:0]       funct3M,
  input  logic [DPW-1:0]   aluresultM,
  input  logic [DPW-1:0]   Rd2M,
  input  logic [ADW-1:0]   RdM,
  output logic             stallM,
  mem_wb_stage_if.master   dmem,
  output logic             validW,
  output logic             regwriteW,
  output logic             resultsrcW,
  output logic [DPW-1:0]   aluresultW,
  output logic [DPW-1:0]   ReadDataW,
  output logic [ADW-1:0]   RdW,
  output logic             misalignW,
  output logic             buserrW
);
  localparam int BEW  = DPW / 8;
  localparam int OFFW = $clog2(BEW);
  localparam int CNTW = $clog2(TimeoutCycles);
  localparam logic [CNTW-1:0] c_cnt_last = CNTW'(TimeoutCycles - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;

  logic [OFFW-1:0] w_off;
  logic [OFFW-1:0] w_amask;
  logic [1:0]      w_lg;
  logic [3:0]      w_nbytes;
  logic            w_legal;
  logic            w_memop, w_misalign, w_go, w_load, w_timeout;
  logic [BEW-1:0]  w_be;
  logic [DPW-1:0]  w_wdata, w_rsh, w_mask, w_ld;
  logic            w_sbit;

  assign w_off = aluresultM[OFFW-1:0];

  // Illegal encodings are clamped to byte size so lane math stays in range.
  always_comb begin
    w_lg    = 2'd0;
    w_legal = 1'b1;
    case (funct3M)
      3'b000, 3'b100: w_lg = 2'd0;
      3'b001, 3'b101: w_lg = 2'd1;
      3'b010:         w_lg = 2'd2;
      3'b110: begin
        w_lg    = (DPW == 64) ? 2'd2 : 2'd0;
        w_legal = (DPW == 64);
      end
      3'b011: begin
        w_lg    = (DPW == 64) ? 2'd3 : 2'd0;
        w_legal = (DPW == 64);
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_nbytes   = 4'd1 << w_lg;
  assign w_amask    = OFFW'(w_nbytes - 4'd1);
  assign w_memop    = validM & (resultsrcM | memwriteM);
  assign w_misalign = w_memop & (~w_legal | (|(w_off & w_amask)));
  assign w_go       = w_memop & ~w_misalign;
  assign w_load     = w_go & ~memwriteM;
  assign w_timeout  = (r_state == S_WAIT) & w_go & ~dmem.dmem_ack & (r_cnt == c_cnt_last);
  assign stallM     = w_go & ~dmem.dmem_ack & ~w_timeout;

  // Request fields come straight from M, which upstream holds while stalled.
  assign dmem.dmem_req   = w_go & ~rst;
  assign dmem.dmem_we    = w_go & memwriteM;
  assign dmem.dmem_addr  = {aluresultM[DPW-1:OFFW], {OFFW{1'b0}}};
  assign dmem.dmem_be    = w_be;
  assign dmem.dmem_wdata = w_wdata;

  always_comb begin
    w_be = '0;
    for (int i = 0; i < BEW; i++) begin
      if (w_go && (i >= int'(w_off)) && (i < int'(w_off) + int'(w_nbytes)))
        w_be[i] = 1'b1;
    end
  end

  always_comb begin
    w_wdata = Rd2M;
    case (w_lg)
      2'd0: for (int i = 0; i < DPW / 8; i++)  w_wdata[8*i +: 8]   = Rd2M[7:0];
      2'd1: for (int i = 0; i < DPW / 16; i++) w_wdata[16*i +: 16] = Rd2M[15:0];
      2'd2: for (int i = 0; i < DPW / 32; i++) w_wdata[32*i +: 32] = Rd2M[31:0];
      default: w_wdata = Rd2M;
    endcase
  end

  assign w_rsh = dmem.dmem_rdata >> {w_off, 3'b000};

  always_comb begin
    w_mask = '1;
    w_sbit = w_rsh[DPW-1];
    case (w_lg)
      2'd0: begin w_mask = DPW'(8'hFF);         w_sbit = w_rsh[7];  end
      2'd1: begin w_mask = DPW'(16'hFFFF);      w_sbit = w_rsh[15]; end
      2'd2: begin w_mask = DPW'(32'hFFFF_FFFF); w_sbit = w_rsh[31]; end
      default: begin w_mask = '1; w_sbit = w_rsh[DPW-1]; end
    endcase
  end

  assign w_ld = (w_rsh & w_mask) | ({DPW{w_sbit & ~funct3M[2]}} & ~w_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_go && !dmem.dmem_ack) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = CNTW'(1);
        end
      end
      S_WAIT: begin
        if (!w_go || dmem.dmem_ack || w_timeout) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNTW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // A stalled cycle sends a bubble; data fields keep their last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validW     <= 1'b0;
      regwriteW  <= 1'b0;
      resultsrcW <= 1'b0;
      aluresultW <= '0;
      ReadDataW  <= '0;
      RdW        <= '0;
      misalignW  <= 1'b0;
      buserrW    <= 1'b0;
    end else if (stallM) begin
      validW    <= 1'b0;
      regwriteW <= 1'b0;
    end else begin
      validW     <= validM;
      regwriteW  <= regwriteM & validM & ~w_misalign & ~w_timeout;
      resultsrcW <= resultsrcM;
      aluresultW <= aluresultM;
      ReadDataW  <= (w_load & dmem.dmem_ack) ? w_ld : '0;
      RdW        <= RdM;
      misalignW  <= w_misalign;
      buserrW    <= w_timeout;
    end
  end
endmodule
`default_nettype wire
